// File: rtl/tcu_mem_read_responder_pkg.sv
// Shared TCU/NoC constants, error codes and responder state encoding.
// Beat size and 33-bit byte arithmetic helpers live here so both RTL files agree.
package tcu_mem_read_responder_pkg;

    localparam int NOC_DATA_SIZE   = 64;
    localparam int NOC_ADDR_SIZE   = 32;
    localparam int NOC_CHIPID_SIZE = 6;
    localparam int NOC_MODID_SIZE  = 8;
    localparam int TCU_ERROR_SIZE  = 5;

    typedef logic [TCU_ERROR_SIZE-1:0] tcu_error_t;

    localparam tcu_error_t TCU_ERROR_NONE          = 5'd0;
    localparam tcu_error_t TCU_ERROR_UNALIGNED     = 5'd1;
    localparam tcu_error_t TCU_ERROR_OUT_OF_BOUNDS = 5'd2;

    localparam logic [32:0] BEAT_BYTES = 33'd8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_SEND    = 2'd2,
        ST_ERR_RSP = 2'd3
    } memrsp_state_e;

    // Bytes carried by one beat given the bytes still outstanding.
    function automatic logic [31:0] beat_size(input logic [32:0] remaining);
        return (remaining > BEAT_BYTES) ? BEAT_BYTES[31:0] : remaining[31:0];
    endfunction

endpackage

// File: rtl/tcu_mem_rsp_range_check.sv
// Combinational alignment and bounds check of a read request.
// Alignment is reported ahead of the bounds violation.
module tcu_mem_rsp_range_check
    import tcu_mem_read_responder_pkg::*;
#(
    parameter logic [31:0] MEM_SIZE_BYTES = 32'h0010_0000
) (
    input  logic [NOC_ADDR_SIZE-1:0] raddr,
    input  logic [31:0]              size,
    output tcu_error_t               err_code
);

    logic [32:0] end_addr;

    always_comb begin
        end_addr = {1'b0, raddr} + {1'b0, size};
        if (raddr[2:0] != 3'b000) begin
            err_code = TCU_ERROR_UNALIGNED;
        end else if (end_addr > {1'b0, MEM_SIZE_BYTES}) begin
            err_code = TCU_ERROR_OUT_OF_BOUNDS;
        end else begin
            err_code = TCU_ERROR_NONE;
        end
    end

endmodule

// File: rtl/tcu_mem_read_responder.sv
// TCU memory-read responder: serves a NoC read request as 8-byte response beats.
// Optional stall timeout/abandon logic is enabled by TCU_MEMRSP_STALL_TIMEOUT_EN.
module tcu_mem_read_responder
    import tcu_mem_read_responder_pkg::*;
#(
    parameter logic [31:0] MEM_SIZE_BYTES = 32'h0010_0000
`ifdef TCU_MEMRSP_STALL_TIMEOUT_EN
    , parameter logic [31:0] TIMEOUT_STALL_CYCLES = 32'd1000
`endif
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    // Request: accepted on a cycle with req_valid_i && req_ready_o; valid need
    // not wait for ready, and the fields are sampled only in that cycle.
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [NOC_ADDR_SIZE-1:0]   req_raddr_i,
    input  logic [NOC_DATA_SIZE-1:0]   req_data0_i,
    input  logic [NOC_CHIPID_SIZE-1:0] req_chipid_i,
    input  logic [NOC_MODID_SIZE-1:0]  req_modid_i,
    output logic                       mem_en_o,
    output logic [NOC_ADDR_SIZE-1:0]   mem_addr_o,
    input  logic [NOC_DATA_SIZE-1:0]   mem_rdata_i,
    input  logic                       noc_stall_i,
    output logic                       noc_wrreq_o,
    output logic [NOC_DATA_SIZE-1:0]   noc_data0_o,
    output logic [NOC_ADDR_SIZE-1:0]   noc_addr_o,
    output logic [NOC_CHIPID_SIZE-1:0] noc_chipid_o,
    output logic [NOC_MODID_SIZE-1:0]  noc_modid_o,
    output logic [31:0]                noc_rsp_size_o,
    output tcu_error_t                 noc_rsp_error_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       drop_o,
    output memrsp_state_e              state_o
);

    memrsp_state_e              state_q, state_d;
    logic [NOC_ADDR_SIZE-1:0]   raddr_q, laddr_q;
    logic [31:0]                size_q;
    logic [NOC_CHIPID_SIZE-1:0] chipid_q;
    logic [NOC_MODID_SIZE-1:0]  modid_q;
    logic [32:0]                offset_q, offset_next;
    logic [NOC_DATA_SIZE-1:0]   data_q;
    tcu_error_t                 err_q, range_err;
    logic                       first_q;
    logic                       accept, beat_state, beat_accept, last_beat, timeout;

    tcu_mem_rsp_range_check #(
        .MEM_SIZE_BYTES(MEM_SIZE_BYTES)
    ) u_range_check (
        .raddr    (req_raddr_i),
        .size     (req_data0_i[63:32]),
        .err_code (range_err)
    );

    assign accept      = (state_q == ST_IDLE) && req_valid_i;
    assign beat_state  = (state_q == ST_SEND) || (state_q == ST_ERR_RSP);
    assign beat_accept = beat_state && !noc_stall_i;
    assign offset_next = offset_q + BEAT_BYTES;
    assign last_beat   = offset_next >= {1'b0, size_q};

`ifdef TCU_MEMRSP_STALL_TIMEOUT_EN
    logic [31:0] stall_cnt_q;

    // Fires on the stalled cycle that pushes the count past the limit.
    assign timeout = beat_state && noc_stall_i && (stall_cnt_q >= TIMEOUT_STALL_CYCLES);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= '0;
        end else if (beat_state && noc_stall_i && !timeout) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (range_err != TCU_ERROR_NONE) begin
                        state_d = ST_ERR_RSP;
                    end else if (req_data0_i[63:32] == 32'd0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_SEND;
            ST_SEND: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (beat_accept) begin
                    state_d = last_beat ? ST_IDLE : ST_READ;
                end
            end
            ST_ERR_RSP: begin
                if (timeout || beat_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request context and beat data; memory data arrives the cycle after READ.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            raddr_q  <= '0;
            laddr_q  <= '0;
            size_q   <= '0;
            chipid_q <= '0;
            modid_q  <= '0;
            offset_q <= '0;
            data_q   <= '0;
            err_q    <= TCU_ERROR_NONE;
            first_q  <= 1'b0;
        end else begin
            first_q <= (state_q == ST_READ);
            if (accept) begin
                raddr_q  <= req_raddr_i;
                size_q   <= req_data0_i[63:32];
                laddr_q  <= req_data0_i[31:0];
                chipid_q <= req_chipid_i;
                modid_q  <= req_modid_i;
                offset_q <= '0;
                data_q   <= '0;
                err_q    <= range_err;
            end
            if ((state_q == ST_SEND) && first_q) begin
                data_q <= mem_rdata_i;
            end
            if ((state_q == ST_SEND) && beat_accept) begin
                offset_q <= offset_next;
            end
        end
    end

    always_comb begin
        req_ready_o     = (state_q == ST_IDLE);
        mem_en_o        = 1'b0;
        mem_addr_o      = '0;
        noc_wrreq_o     = beat_state;
        noc_data0_o     = '0;
        noc_addr_o      = '0;
        noc_chipid_o    = '0;
        noc_modid_o     = '0;
        noc_rsp_size_o  = '0;
        noc_rsp_error_o = TCU_ERROR_NONE;
        busy_o          = (state_q != ST_IDLE);
        done_o          = beat_accept && ((state_q == ST_ERR_RSP) || last_beat);
        drop_o          = timeout;
        state_o         = state_q;
        case (state_q)
            ST_READ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = raddr_q + offset_q[31:0];
            end
            ST_SEND: begin
                // First SEND cycle forwards the memory word it is capturing.
                noc_data0_o    = first_q ? mem_rdata_i : data_q;
                noc_addr_o     = laddr_q + offset_q[31:0];
                noc_chipid_o   = chipid_q;
                noc_modid_o    = modid_q;
                noc_rsp_size_o = beat_size({1'b0, size_q} - offset_q);
            end
            ST_ERR_RSP: begin
                noc_addr_o      = laddr_q;
                noc_chipid_o    = chipid_q;
                noc_modid_o     = modid_q;
                noc_rsp_error_o = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tcu_mem_read_responder.sv
// Bench for tcu_mem_read_responder: directed cases plus randomized requests
// checked every cycle against a beat-list model built from the request rules.
module tb_tcu_mem_read_responder;
  import tcu_mem_read_responder_pkg::*;

  localparam logic [31:0] MEM = 32'h0010_0000;
  localparam int BW = 152;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic req_valid_i, req_ready_o;
  logic [31:0] req_raddr_i;
  logic [63:0] req_data0_i;
  logic [NOC_CHIPID_SIZE-1:0] req_chipid_i, noc_chipid_o;
  logic [NOC_MODID_SIZE-1:0] req_modid_i, noc_modid_o;
  logic mem_en_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_rdata_i;
  logic noc_stall_i, noc_wrreq_o;
  logic [63:0] noc_data0_o;
  logic [31:0] noc_addr_o, noc_rsp_size_o;
  tcu_error_t noc_rsp_error_o;
  logic busy_o, done_o, drop_o;
  memrsp_state_e state_o;

  tcu_mem_read_responder #(
    .MEM_SIZE_BYTES(MEM)
`ifdef TCU_MEMRSP_STALL_TIMEOUT_EN
    , .TIMEOUT_STALL_CYCLES(32'd10)
`endif
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_raddr_i(req_raddr_i), .req_data0_i(req_data0_i),
    .req_chipid_i(req_chipid_i), .req_modid_i(req_modid_i),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .noc_stall_i(noc_stall_i), .noc_wrreq_o(noc_wrreq_o),
    .noc_data0_o(noc_data0_o), .noc_addr_o(noc_addr_o),
    .noc_chipid_o(noc_chipid_o), .noc_modid_o(noc_modid_o),
    .noc_rsp_size_o(noc_rsp_size_o), .noc_rsp_error_o(noc_rsp_error_o),
    .busy_o(busy_o), .done_o(done_o), .drop_o(drop_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail = 0;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  bit exp_last_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] log_addr[$], log_size[$], log_err[$], mem_log[$];
  int done_cnt = 0;
  int drop_cnt = 0;
  bit inflight = 0;
  int cyc = 0;
  int next_offer = 0;
  bit prev_stalled = 0;
  logic [BW-1:0] prev_beat;
  bit stall_rand = 0;
  bit stall_force = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, a * 32'h9E37_79B9};
  endfunction

  function automatic logic [BW-1:0] pack_beat(input logic [NOC_CHIPID_SIZE-1:0] cid,
      input logic [NOC_MODID_SIZE-1:0] mid, input tcu_error_t err, input logic [31:0] sz,
      input logic [31:0] addr, input logic [63:0] data);
    return {8'(cid), 8'(mid), 8'(err), sz, addr, data};
  endfunction

  // Expected response list for one request, from the request rules alone.
  task automatic model_push(input logic [31:0] ra, input logic [31:0] sz, input logic [31:0] la,
      input logic [NOC_CHIPID_SIZE-1:0] cid, input logic [NOC_MODID_SIZE-1:0] mid,
      output bit one_cycle);
    longint unsigned end_a;
    end_a = longint'(ra) + longint'(sz);
    one_cycle = 1;
    if (ra % 8 != 0) begin
      exp_q.push_back(pack_beat(cid, mid, TCU_ERROR_UNALIGNED, 0, la, 0));
      exp_last_q.push_back(1);
    end else if (end_a > longint'(MEM)) begin
      exp_q.push_back(pack_beat(cid, mid, TCU_ERROR_OUT_OF_BOUNDS, 0, la, 0));
      exp_last_q.push_back(1);
    end else if (sz == 0) begin
      exp_q.push_back(pack_beat(cid, mid, TCU_ERROR_NONE, 0, la, 0));
      exp_last_q.push_back(1);
    end else begin
      one_cycle = 0;
      for (longint unsigned off = 0; off < longint'(sz); off += 8) begin
        logic [31:0] o32, bsz;
        o32 = off[31:0];
        bsz = (longint'(sz) - off >= 8) ? 32'd8 : 32'(longint'(sz) - off);
        mem_q.push_back(ra + o32);
        exp_q.push_back(pack_beat(cid, mid, TCU_ERROR_NONE, bsz, la + o32, mem_word(ra + o32)));
        exp_last_q.push_back(off + 8 >= longint'(sz));
      end
    end
  endtask

  // ---------------- memory and stall drivers ----------------
  initial begin
    logic rd_en;
    logic [31:0] rd_addr;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      rd_en = mem_en_o;
      rd_addr = mem_addr_o;
      @(posedge clk_i);
      #1;
      mem_rdata_i = rd_en ? mem_word(rd_addr) : {$urandom, $urandom};
    end
  end

  initial begin
    noc_stall_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      noc_stall_i = stall_rand ? ($urandom_range(0, 99) < 30) : stall_force;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [BW-1:0] act;
    bit last, inflight_next, one_cycle;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!reset_n_i) begin
        exp_q.delete(); exp_last_q.delete(); mem_q.delete();
        inflight = 0; prev_stalled = 0;
        continue;
      end
      inflight_next = inflight;
      chk("req_ready", req_ready_o, !inflight);
      chk("busy", busy_o, inflight);
`ifndef TCU_MEMRSP_STALL_TIMEOUT_EN
      chk("drop_tied", drop_o, 0);
`endif
      if (mem_en_o) begin
        mem_log.push_back(mem_addr_o);
        if (mem_q.size() == 0) fail_now("mem_en_unexpected");
        else begin
          chk("mem_addr", mem_addr_o, mem_q.pop_front());
          chk("mem_en_cycle", cyc, next_offer - 1);
        end
      end
      if (noc_wrreq_o) begin
        act = pack_beat(noc_chipid_o, noc_modid_o, noc_rsp_error_o, noc_rsp_size_o,
                        noc_addr_o, noc_data0_o);
        if (prev_stalled) chk("stall_hold", act, prev_beat);
        else chk("beat_cycle", cyc, next_offer);
        if (!noc_stall_i) begin
          if (exp_q.size() == 0) fail_now("beat_unexpected");
          else begin
            chk("beat", act, exp_q.pop_front());
            last = exp_last_q.pop_front();
            chk("done", done_o, last);
            log_addr.push_back(noc_addr_o);
            log_size.push_back(noc_rsp_size_o);
            log_err.push_back(32'(noc_rsp_error_o));
            if (done_o) done_cnt++;
            if (last) inflight_next = 0;
            else next_offer = cyc + 2;
          end
        end else begin
          chk("done_stalled", done_o, 0);
        end
        prev_stalled = noc_stall_i;
        prev_beat = act;
      end else begin
        if (prev_stalled) fail_now("stalled_beat_vanished");
        chk("done_idle", done_o, 0);
        prev_stalled = 0;
      end
`ifdef TCU_MEMRSP_STALL_TIMEOUT_EN
      if (drop_o) begin
        chk("drop_while_stalled", {noc_wrreq_o, noc_stall_i}, 2'b11);
        drop_cnt++;
        exp_q.delete(); exp_last_q.delete(); mem_q.delete();
        inflight_next = 0;
        prev_stalled = 0;
      end
`endif
      if (req_valid_i && req_ready_o) begin
        model_push(req_raddr_i, req_data0_i[63:32], req_data0_i[31:0],
                   req_chipid_i, req_modid_i, one_cycle);
        inflight_next = 1;
        next_offer = cyc + (one_cycle ? 1 : 2);
      end
      inflight = inflight_next;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [31:0] ra, input logic [31:0] sz, input logic [31:0] la);
    int k;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1;
    req_raddr_i = ra;
    req_data0_i = {sz, la};
    req_chipid_i = NOC_CHIPID_SIZE'($urandom);
    req_modid_i = NOC_MODID_SIZE'($urandom);
    k = 0;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) break;
      k++;
      if (k > 3000) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while ((busy_o || exp_q.size() != 0) && k < 3000);
    if (busy_o || exp_q.size() != 0) fail_now("wait_done_timeout");
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_size.delete(); log_err.delete(); mem_log.delete();
    done_cnt = 0;
    drop_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_wrreq", noc_wrreq_o, 0);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_data", noc_data0_o, 0);
    chk("rst_addr", noc_addr_o, 0);
    chk("rst_size", noc_rsp_size_o, 0);
    chk("rst_err", noc_rsp_error_o, 0);
    chk("rst_ids", {noc_chipid_o, noc_modid_o}, 0);
    chk("rst_done_drop", {done_o, drop_o}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    logic [31:0] ra, sz;
    reset_n_i = 1'b0;
    req_valid_i = 1'b0;
    req_raddr_i = '0;
    req_data0_i = '0;
    req_chipid_i = '0;
    req_modid_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs();
    reset_n_i = 1'b1;

    // Three-beat read with a short tail.
    clear_logs();
    send_req(32'h100, 32'd20, 32'h4000);
    wait_done();
    chk("t1_beats", log_size.size(), 3);
    if (log_size.size() == 3) begin
      chk("t1_sizes", {log_size[0], log_size[1], log_size[2]}, {32'd8, 32'd8, 32'd4});
      chk("t1_addrs", {log_addr[0], log_addr[1], log_addr[2]}, {32'h4000, 32'h4008, 32'h4010});
    end
    chk("t1_mem_reads", mem_log.size(), 3);
    if (mem_log.size() == 3)
      chk("t1_mem_addrs", {mem_log[0], mem_log[1], mem_log[2]}, {32'h100, 32'h108, 32'h110});
    chk("t1_done", done_cnt, 1);

    // Zero-size request.
    clear_logs();
    send_req(32'h200, 32'd0, 32'h5000);
    wait_done();
    chk("t2_beats", log_size.size(), 1);
    if (log_size.size() == 1) chk("t2_size_err", {log_size[0], log_err[0]}, {32'd0, 32'd0});
    chk("t2_no_mem", mem_log.size(), 0);

    // Unaligned address.
    clear_logs();
    send_req(32'h104, 32'd16, 32'h6000);
    wait_done();
    chk("t3_beats", log_err.size(), 1);
    if (log_err.size() == 1)
      chk("t3_err", {log_err[0], log_addr[0]}, {32'(TCU_ERROR_UNALIGNED), 32'h6000});
    chk("t3_no_mem", mem_log.size(), 0);

    // Top-of-memory bounds.
    clear_logs();
    send_req(MEM - 32'd8, 32'd16, 32'h7000);
    wait_done();
    chk("t4_beats", log_err.size(), 1);
    if (log_err.size() == 1) chk("t4_oob", log_err[0], 32'(TCU_ERROR_OUT_OF_BOUNDS));
    clear_logs();
    send_req(MEM - 32'd8, 32'd8, 32'h7000);
    wait_done();
    chk("t5_beats", log_size.size(), 1);
    if (log_size.size() == 1) chk("t5_ok", {log_size[0], log_err[0]}, {32'd8, 32'd0});
    if (mem_log.size() == 1) chk("t5_mem", mem_log[0], MEM - 32'd8);
    else fail_now("t5_mem_count");

    // Five stalled cycles on beat 2 of a 16-byte read.
    clear_logs();
    send_req(32'h800, 32'd16, 32'h9000);
    k = 0;
    do begin @(negedge clk_i); k++; end while (!noc_wrreq_o && k < 50);
    @(posedge clk_i);
    #1;
    stall_force = 1;
    k = 0;
    for (int n = 0; n < 5 && k < 100; k++) begin
      @(negedge clk_i);
      if (noc_wrreq_o && noc_stall_i) n++;
    end
    if (k >= 100) fail_now("t6_stall_window");
    @(posedge clk_i);
    #1;
    stall_force = 0;
    wait_done();
    chk("t6_beats", log_size.size(), 2);
    chk("t6_mem_reads", mem_log.size(), 2);
    chk("t6_done", done_cnt, 1);

`ifdef TCU_MEMRSP_STALL_TIMEOUT_EN
    // Stall held until the responder gives up.
    clear_logs();
    send_req(32'h900, 32'd16, 32'hA000);
    stall_force = 1;
    k = 0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk_i);
        k++;
        if (noc_wrreq_o && noc_stall_i) n++;
      end while (!drop_o && k < 100);
      chk("t7_drop_seen", drop_o, 1);
      chk("t7_drop_cycle", n, 11);
    end
    @(posedge clk_i);
    #1;
    stall_force = 0;
    @(negedge clk_i);
    chk("t7_ready_after", req_ready_o, 1);
    chk("t7_no_done", done_cnt, 0);
    chk("t7_beats", log_size.size(), 0);
`endif

    // Reset in the middle of a response.
    send_req(32'h1000, 32'd32, 32'hB000);
    k = 0;
    do begin @(negedge clk_i); k++; end while (!noc_wrreq_o && k < 50);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // Randomized requests with random stalls, back to back.
    stall_rand = 1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      sz = $urandom_range(0, 64);
      ra = {12'd0, 17'($urandom_range(0, 32'h1FFFF)), 3'b000};
      if (k == 0) ra[2:0] = 3'($urandom_range(1, 7));
      else if (k == 1) ra = MEM - 32'(8 * $urandom_range(0, 8));
      send_req(ra, sz, $urandom);
    end
    wait_done();
    stall_rand = 0;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
